// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port plus the datapath-facing
// instruction handshake and redirect inputs.
interface fetch_stage_if #(
    parameter int WD = 32
);
    logic          imem_req;
    logic [WD-1:0] imem_addr;
    logic [WD-1:0] imem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [WD-1:0] instr;
    logic [WD-1:0] PC;
    logic [WD-1:0] PCPlus4;
    logic          Branch;
    logic          Jump;
    logic          JumpReg;
    logic          flag;
    logic [WD-1:0] IMM;
    logic [WD-1:0] DOutAlu;
    logic          halted;

    modport master (
        output imem_req, imem_addr,
        output out_valid, instr, PC, PCPlus4, halted,
        input  imem_rdata, out_ready,
        input  Branch, Jump, JumpReg, flag, IMM, DOutAlu
    );

    modport slave (
        input  imem_req, imem_addr,
        input  out_valid, instr, PC, PCPlus4, halted,
        output imem_rdata, out_ready,
        output Branch, Jump, JumpReg, flag, IMM, DOutAlu
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, 1-cycle imem reads, skid FIFO with bypass,
// and same-cycle branch/jump redirect with sticky misalignment halt.
module fetch_stage #(
    parameter int               WD       = 32,
    parameter logic [WD-1:0]    RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_stage_if.master  bus
);
    localparam int            CW  = $clog2(DEPTH + 1);
    localparam logic [WD-1:0] NOP = WD'(32'h0000_0013);

    typedef enum logic {RUN, HALT} state_e;

    state_e        state_q;
    logic [WD-1:0] fetch_pc_q;
    logic          infl_q;
    logic [WD-1:0] infl_pc_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WD-1:0] fifo_ins_q [DEPTH];
    logic [WD-1:0] fifo_pc_q  [DEPTH];
    logic [WD-1:0] fifo_ins_d [DEPTH];
    logic [WD-1:0] fifo_pc_d  [DEPTH];

    logic          has_q;
    logic          valid;
    logic [WD-1:0] head_ins;
    logic [WD-1:0] head_pc;
    logic          pop;
    logic          redir;
    logic [WD-1:0] target;
    logic          misal;
    logic          room;
    logic          req;
    logic [WD-1:0] addr;
    logic          push;

    assign has_q    = (cnt_q != '0);
    assign head_ins = has_q ? fifo_ins_q[0] : bus.imem_rdata;
    assign head_pc  = has_q ? fifo_pc_q[0]  : infl_pc_q;
    assign valid    = has_q | infl_q;

    assign pop   = valid & bus.out_ready;
    assign redir = pop & (bus.Jump | bus.JumpReg |
                          (bus.Branch & bus.flag));

    assign target = bus.JumpReg ? (bus.DOutAlu & ~WD'(1))
                                : head_pc + bus.IMM;
    assign misal  = redir & (target[1:0] != 2'b00);

    assign room = (32'(cnt_q) + 32'(infl_q)) < 32'(DEPTH);
    // Reset gates the request so memory sees nothing while held in reset.
    assign req  = rst_n & (state_q == RUN) & ~misal & (redir | room);
    assign addr = redir ? target : fetch_pc_q;

    // A popped bypass head or a flushed response must not enter the FIFO.
    assign push = infl_q & ~(pop & ~has_q) & ~redir;

    assign bus.imem_req  = req;
    assign bus.imem_addr = addr;
    assign bus.out_valid = valid;
    assign bus.instr     = valid ? head_ins : NOP;
    assign bus.PC        = valid ? head_pc  : '0;
    assign bus.PCPlus4   = bus.PC + WD'(4);
    assign bus.halted    = (state_q == HALT);

    always_comb begin
        fifo_ins_d = fifo_ins_q;
        fifo_pc_d  = fifo_pc_q;
        cnt_d      = cnt_q;
        if (pop && has_q) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                fifo_ins_d[i] = fifo_ins_q[i+1];
                fifo_pc_d[i]  = fifo_pc_q[i+1];
            end
            cnt_d = cnt_q - CW'(1);
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(cnt_d)) begin
                    fifo_ins_d[i] = bus.imem_rdata;
                    fifo_pc_d[i]  = infl_pc_q;
                end
            end
            cnt_d = cnt_d + CW'(1);
        end
        if (redir) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            infl_q     <= 1'b0;
            infl_pc_q  <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_ins_q[i] <= '0;
                fifo_pc_q[i]  <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            fifo_ins_q <= fifo_ins_d;
            fifo_pc_q  <= fifo_pc_d;
            unique case (1'b1)
                misal: begin
                    state_q <= HALT;
                    infl_q  <= 1'b0;
                end
                req: begin
                    infl_q     <= 1'b1;
                    infl_pc_q  <= addr;
                    fetch_pc_q <= addr + WD'(4);
                end
                default: begin
                    infl_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, backpressure,
// branches, JALR, misaligned halt and asynchronous reset.
module tb_fetch_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fetch_stage_if #(.WD(32)) bus ();

    fetch_stage #(
        .WD(32),
        .RESET_PC(32'h0),
        .DEPTH(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word n holds value n, one cycle after the request.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= {2'b00, bus.imem_addr[31:2]};
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rdy,
                         input logic br, input logic fl,
                         input logic jmp, input logic jr,
                         input logic [31:0] imm,
                         input logic [31:0] alu);
        @(negedge clk);
        bus.out_ready = rdy;
        bus.Branch    = br;
        bus.flag      = fl;
        bus.Jump      = jmp;
        bus.JumpReg   = jr;
        bus.IMM       = imm;
        bus.DOutAlu   = alu;
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(rdy, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.imem_rdata = 32'h0;
        idle(1'b1);
        idle(1'b1);
        check("rst_req",   {31'b0, bus.imem_req},  32'h0);
        check("rst_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_halt",  {31'b0, bus.halted},    32'h0);
        check("rst_instr", bus.instr, 32'h13);
        check("rst_pc",    bus.PC,    32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("c0_req",   {31'b0, bus.imem_req},  32'h1);
        check("c0_addr",  bus.imem_addr, 32'h0);
        check("c0_valid", {31'b0, bus.out_valid}, 32'h0);

        idle(1'b1);
        check("c1_valid", {31'b0, bus.out_valid}, 32'h1);
        check("c1_pc",    bus.PC,        32'h0);
        check("c1_instr", bus.instr,     32'h0);
        check("c1_addr",  bus.imem_addr, 32'h4);
        idle(1'b1);
        check("c2_pc",    bus.PC,      32'h4);
        check("c2_instr", bus.instr,   32'h1);
        check("c2_pc4",   bus.PCPlus4, 32'h8);

        idle(1'b0);
        check("bp3_pc",   bus.PC, 32'h8);
        check("bp3_req",  {31'b0, bus.imem_req}, 32'h1);
        check("bp3_addr", bus.imem_addr, 32'hc);
        idle(1'b0);
        check("bp4_req",  {31'b0, bus.imem_req}, 32'h0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        check("bp7_req",   {31'b0, bus.imem_req}, 32'h0);
        check("bp7_pc",    bus.PC,    32'h8);
        check("bp7_instr", bus.instr, 32'h2);
        idle(1'b1);
        check("rel8_pc",  bus.PC, 32'h8);
        check("rel8_req", {31'b0, bus.imem_req}, 32'h0);
        idle(1'b1);
        check("rel9_pc",    bus.PC,        32'hc);
        check("rel9_instr", bus.instr,     32'h3);
        check("rel9_addr",  bus.imem_addr, 32'h10);

        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        check("br_pc",   bus.PC,        32'h10);
        check("br_addr", bus.imem_addr, 32'h50);
        check("br_req",  {31'b0, bus.imem_req}, 32'h1);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
        check("tgt_pc",    bus.PC,        32'h50);
        check("tgt_instr", bus.instr,     32'h14);
        check("nt_addr",   bus.imem_addr, 32'h54);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h101);
        check("nt_pc",   bus.PC,        32'h54);
        check("jr_addr", bus.imem_addr, 32'h100);

        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2, 32'h0);
        check("jr_pc",    bus.PC,    32'h100);
        check("jr_instr", bus.instr, 32'h40);
        check("mis_req",  {31'b0, bus.imem_req}, 32'h0);

        idle(1'b1);
        check("h_halt",  {31'b0, bus.halted},    32'h1);
        check("h_valid", {31'b0, bus.out_valid}, 32'h0);
        check("h_req",   {31'b0, bus.imem_req},  32'h0);
        check("h_instr", bus.instr, 32'h13);
        check("h_pc",    bus.PC,    32'h0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        check("h3_halt",  {31'b0, bus.halted},    32'h1);
        check("h3_valid", {31'b0, bus.out_valid}, 32'h0);
        check("h3_req",   {31'b0, bus.imem_req},  32'h0);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("hr_halt",  {31'b0, bus.halted},    32'h0);
        check("hr_valid", {31'b0, bus.out_valid}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        check("r2_addr", bus.imem_addr, 32'h0);
        idle(1'b0);
        check("r2c1_pc",  bus.PC, 32'h0);
        check("r2c1_req", {31'b0, bus.imem_req}, 32'h1);
        idle(1'b0);
        check("r2c2_req", {31'b0, bus.imem_req}, 32'h0);
        idle(1'b0);
        check("full_valid", {31'b0, bus.out_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_valid", {31'b0, bus.out_valid}, 32'h0);
        check("mr_req",   {31'b0, bus.imem_req},  32'h0);
        check("mr_pc",    bus.PC,    32'h0);
        check("mr_instr", bus.instr, 32'h13);

        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("rs_req",  {31'b0, bus.imem_req}, 32'h1);
        check("rs_addr", bus.imem_addr, 32'h0);
        idle(1'b1);
        check("rs_valid", {31'b0, bus.out_valid}, 32'h1);
        check("rs_pc",    bus.PC,    32'h0);
        check("rs_instr", bus.instr, 32'h0);
        idle(1'b1);
        check("rs2_pc", bus.PC, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
